mat_scalar_div_seq: RTL and testbench

Sequential, lane-parametrised matrix-by-scalar divider: divides every element of a SIZE_A x SIZE_B matrix of `double` by one scalar using LANES shared `double_divide_num` instances, issuing groups of elements in turn. It is the area-scalable successor to the fully parallel matrix divider used in the fetal-ECG normalisation path (covariance/whitening scaling). It adds:

- a start/busy/done handshake,
- held outputs,
- divide-by-zero detection,
- abort.

---
 rtl/fp_double.sv | 17 +
 rtl/double_divide_num.sv | 151 +++++++++++++++
 rtl/mat_scalar_div_seq.sv | 159 +++++++++++++++
 tb/tb_mat_scalar_div_seq.sv | 519 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_double.sv
// Shared IEEE-754 binary64 helpers for the normalisation datapath.
// Raw bit container, zero test and the divider's fixed latency.
package fp_double;

    typedef logic [63:0] double;

    localparam double DOUBLE_POS_ZERO = 64'h0000_0000_0000_0000;
    localparam double DOUBLE_QNAN     = 64'h7FF8_0000_0000_0000;

    // start-to-valid latency of double_divide_num
    localparam int DOUBLE_DIV_LATENCY = 58;

    function automatic logic double_is_zero(input double x);
        return x[62:0] == 63'd0;
    endfunction

endpackage

// File: rtl/double_divide_num.sv
// Radix-2 restoring binary64 divider, round-to-nearest-even.
// Fixed latency DOUBLE_DIV_LATENCY; subnormals are flushed to zero.
module double_divide_num
    import fp_double::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start,
    input  double a,
    input  double b,
    output double q,
    output logic  valid
);

    localparam int QB = DOUBLE_DIV_LATENCY - 2;
    localparam int CW = $clog2(QB + 1);

    logic               busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [54:0]        rem_q, rem_d;
    logic [52:0]        den_q, den_d;
    logic [QB-1:0]      quo_q, quo_d;
    logic               sign_q, sign_d;
    logic signed [12:0] exp_q, exp_d;
    logic               spec_q, spec_d;
    double              spec_val_q, spec_val_d;
    double              q_q, q_d;
    logic               valid_q, valid_d;

    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;

    assign a_zero = a[62:52] == 11'd0;
    assign b_zero = b[62:52] == 11'd0;
    assign a_inf  = (&a[62:52]) && (a[51:0] == 52'd0);
    assign b_inf  = (&b[62:52]) && (b[51:0] == 52'd0);
    assign a_nan  = (&a[62:52]) && (a[51:0] != 52'd0);
    assign b_nan  = (&b[62:52]) && (b[51:0] != 52'd0);
    assign sgn    = a[63] ^ b[63];

    logic [51:0]        man;
    logic               grd, stk;
    logic signed [12:0] e_pre, e_fin;
    logic [52:0]        frac_r;
    double              packed_q;

    // quotient integer bit sits at quo[QB-1]; ratio lies in (0.5, 2)
    always_comb begin
        if (quo_q[QB-1]) begin
            man   = quo_q[QB-2:QB-53];
            grd   = quo_q[QB-54];
            stk   = (|quo_q[QB-55:0]) | (|rem_q);
            e_pre = exp_q;
        end else begin
            man   = quo_q[QB-3:QB-54];
            grd   = quo_q[QB-55];
            stk   = (|quo_q[QB-56:0]) | (|rem_q);
            e_pre = exp_q - 13'sd1;
        end
        frac_r = {1'b0, man} + {52'd0, grd & (stk | man[0])};
        e_fin  = frac_r[52] ? e_pre + 13'sd1 : e_pre;
        if (e_fin >= 13'sd2047) begin
            packed_q = {sign_q, 11'h7FF, 52'd0};
        end else if (e_fin <= 13'sd0) begin
            packed_q = {sign_q, 63'd0};
        end else begin
            packed_q = {sign_q, e_fin[10:0], frac_r[51:0]};
        end
    end

    logic        ge;
    logic [54:0] diff;

    always_comb begin
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        den_d      = den_q;
        quo_d      = quo_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        q_d        = q_q;
        valid_d    = 1'b0;
        ge         = rem_q >= {2'b00, den_q};
        diff       = ge ? rem_q - {2'b00, den_q} : rem_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            rem_d  = {2'b00, 1'b1, a[51:0]};
            den_d  = {1'b1, b[51:0]};
            quo_d  = '0;
            sign_d = sgn;
            exp_d  = $signed({2'b00, a[62:52]})
                   - $signed({2'b00, b[62:52]}) + 13'sd1023;
            spec_d = 1'b1;
            if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
                spec_val_d = DOUBLE_QNAN;
            end else if (a_inf | b_zero) begin
                spec_val_d = {sgn, 11'h7FF, 52'd0};
            end else if (a_zero | b_inf) begin
                spec_val_d = {sgn, 63'd0};
            end else begin
                spec_d     = 1'b0;
                spec_val_d = DOUBLE_POS_ZERO;
            end
        end else if (busy_q) begin
            if (cnt_q == CW'(QB)) begin
                busy_d  = 1'b0;
                valid_d = 1'b1;
                q_d     = spec_q ? spec_val_q : packed_q;
            end else begin
                quo_d = {quo_q[QB-2:0], ge};
                rem_d = {diff[53:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            rem_q      <= '0;
            den_q      <= '0;
            quo_q      <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            spec_q     <= 1'b0;
            spec_val_q <= DOUBLE_POS_ZERO;
            q_q        <= DOUBLE_POS_ZERO;
            valid_q    <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            den_q      <= den_d;
            quo_q      <= quo_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            q_q        <= q_d;
            valid_q    <= valid_d;
        end
    end

    assign q     = q_q;
    assign valid = valid_q;

endmodule

// File: rtl/mat_scalar_div_seq.sv
// Matrix-by-scalar divider: SIZE_A x SIZE_B doubles divided by one scalar,
// LANES elements per group through shared double_divide_num instances.
module mat_scalar_div_seq
    import fp_double::*;
#(
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8,
    parameter int LANES  = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start,
    input  logic  abort,
    input  double scale,
    input  double mat     [SIZE_A][SIZE_B],
    output double mat_out [SIZE_A][SIZE_B],
    output logic  busy,
    output logic  done,
    output logic  div_zero
);

    localparam int N  = SIZE_A * SIZE_B;
    localparam int G  = N / LANES;
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    if ((N % LANES) != 0) begin : g_bad_lanes
        $error("LANES must divide SIZE_A*SIZE_B");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [GW-1:0]    g_q, g_d;
    logic [LANES-1:0] got_q, got_d;
    double            scale_q, scale_d;
    double            opnd_q [G][LANES];
    double            opnd_d [G][LANES];
    double            res_q  [G][LANES];
    double            res_d  [G][LANES];
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dstart_q, dstart_d;

    double            mat_flat [G][LANES];
    double            dq [LANES];
    logic [LANES-1:0] dvalid;

    // element k = i*SIZE_B+j lives in group k/LANES, lane k%LANES
    for (genvar k = 0; k < N; k++) begin : g_map
        assign mat_flat[k / LANES][k % LANES] = mat[k / SIZE_B][k % SIZE_B];
        assign mat_out[k / SIZE_B][k % SIZE_B] = res_q[k / LANES][k % LANES];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        double_divide_num u_div (
            .clk   (clk),
            .rst_n (rst_n),
            .start (dstart_q),
            .a     (opnd_q[g_q][l]),
            .b     (scale_q),
            .q     (dq[l]),
            .valid (dvalid[l])
        );
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        got_d   = got_q;
        scale_d = scale_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        dz_d    = dz_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    scale_d = scale;
                    opnd_d  = mat_flat;
                    res_d   = '{default: DOUBLE_POS_ZERO};
                    g_d     = '0;
                    got_d   = '0;
                    dz_d    = double_is_zero(scale);
                    state_d = double_is_zero(scale) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    got_d   = '0;
                end else begin
                    for (int l = 0; l < LANES; l++) begin
                        if (dvalid[l]) begin
                            got_d[l]     = 1'b1;
                            res_d[g_q][l] = dq[l];
                        end
                    end
                    if (&got_d) begin
                        got_d = '0;
                        if (g_q == GW'(G - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            g_d     = g_q + GW'(1);
                            state_d = S_ISSUE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d   = (state_d == S_ISSUE) || (state_d == S_WAIT);
        done_d   = state_d == S_DONE;
        dstart_d = state_d == S_ISSUE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            g_q      <= '0;
            got_q    <= '0;
            scale_q  <= DOUBLE_POS_ZERO;
            opnd_q   <= '{default: DOUBLE_POS_ZERO};
            res_q    <= '{default: DOUBLE_POS_ZERO};
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            got_q    <= got_d;
            scale_q  <= scale_d;
            opnd_q   <= opnd_d;
            res_q    <= res_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dstart_q <= dstart_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_mat_scalar_div_seq.sv
// Self-checking bench for mat_scalar_div_seq against a real-arithmetic
// reference model of the matrix/scalar quotient and its cycle timing.
module tb_mat_scalar_div_seq;
    import fp_double::*;

    localparam int D   = DOUBLE_DIV_LATENCY;
    localparam int G   = 16;
    localparam int TOT = G * (D + 1) + 1;

    typedef double mat8_t [8][8];

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  start = 1'b0;
    logic  abort = 1'b0;
    double scale = 64'd0;
    mat8_t mat;
    mat8_t mat_out;
    logic  busy, done, div_zero;

    logic  s_start = 1'b0;
    logic  s_abort = 1'b0;
    double s_scale = 64'd0;
    double s_mat [2][2];
    double s_out [2][2];
    logic  s_busy, s_done, s_dz;

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    mat_scalar_div_seq #(.SIZE_A(8), .SIZE_B(8), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .scale(scale), .mat(mat), .mat_out(mat_out),
        .busy(busy), .done(done), .div_zero(div_zero)
    );

    mat_scalar_div_seq #(.SIZE_A(2), .SIZE_B(2), .LANES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
        .scale(s_scale), .mat(s_mat), .mat_out(s_out),
        .busy(s_busy), .done(s_done), .div_zero(s_dz)
    );

    function automatic double qdiv(input double a, input double b);
        return $realtobits($bitstoreal(a) / $bitstoreal(b));
    endfunction

    function automatic double rnd_dbl();
        logic [63:0] r;
        r[63:32] = $urandom();
        r[31:0]  = $urandom();
        r[62:52] = 11'(983 + $urandom_range(0, 80));
        return r;
    endfunction

    function automatic void rnd_mat(output mat8_t m);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                m[i][j] = rnd_dbl();
    endfunction

    // expected output with only elements k < upto written
    function automatic void build_exp(input double sc, input mat8_t m,
                                      input int upto, output mat8_t e);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                e[i][j] = (i * 8 + j < upto) ? qdiv(m[i][j], sc) : 64'd0;
    endfunction

    function automatic int first_diff(input mat8_t a, input mat8_t b);
        for (int k = 0; k < 64; k++)
            if (a[k / 8][k % 8] !== b[k / 8][k % 8]) return k;
        return -1;
    endfunction

    task automatic launch(input double sc, input mat8_t m);
        @(negedge clk);
        scale = sc;
        mat   = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // called in cycle 1 of an operation; dc = -1 on timeout
    task automatic wait_done(output int dc);
        int c;
        c  = 1;
        dc = -1;
        while (dc < 0 && c < 20000) begin
            if (done === 1'b1) dc = c;
            else begin
                @(negedge clk);
                c++;
            end
        end
    endtask

    task automatic test_reset();
        mat8_t z;
        int k;
        z = '{default: 64'd0};
        nvec++;
        if ({busy, done, div_zero} !== 3'b000) begin
            nfail++;
            $display("FAIL reset_flags: got %b expected 000",
                     {busy, done, div_zero});
        end
        k = first_diff(mat_out, z);
        nvec++;
        if (k !== -1) begin
            nfail++;
            $display("FAIL reset_mat_out: k=%0d got %h expected 0",
                     k, mat_out[k / 8][k % 8]);
        end
    endtask

    task automatic test_small();
        int c, dc, nd, bb, tot2;
        double ex [4];
        ex[0] = $realtobits(0.5);
        ex[1] = $realtobits(1.0);
        ex[2] = $realtobits(1.5);
        ex[3] = $realtobits(2.0);
        tot2 = 2 * (D + 1) + 1;
        @(negedge clk);
        s_scale = $realtobits(2.0);
        s_mat[0][0] = $realtobits(1.0);
        s_mat[0][1] = $realtobits(2.0);
        s_mat[1][0] = $realtobits(3.0);
        s_mat[1][1] = $realtobits(4.0);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        c = 1; dc = -1; nd = 0; bb = 0;
        while (c <= tot2 + 2) begin
            if (s_done === 1'b1) begin
                nd++;
                if (dc < 0) dc = c;
            end
            if (s_busy !== (c >= 1 && c <= tot2 - 1)) bb++;
            @(negedge clk);
            c++;
        end
        nvec++;
        if (dc !== tot2) begin
            nfail++;
            $display("FAIL small_done_cycle: got %0d expected %0d", dc, tot2);
        end
        nvec++;
        if (nd !== 1) begin
            nfail++;
            $display("FAIL small_done_pulses: got %0d expected 1", nd);
        end
        nvec++;
        if (bb !== 0) begin
            nfail++;
            $display("FAIL small_busy: %0d bad cycles expected 0", bb);
        end
        for (int k = 0; k < 4; k++) begin
            nvec++;
            if (s_out[k / 2][k % 2] !== ex[k]) begin
                nfail++;
                $display("FAIL small_q%0d: got %h expected %h",
                         k, s_out[k / 2][k % 2], ex[k]);
            end
        end
    endtask

    task automatic test_ramp();
        mat8_t m, e;
        double sc, early, late;
        int c, dc, nd, bb, k;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                m[i][j] = $realtobits(real'(i * 8 + j));
        sc = $realtobits(-4.0);
        launch(sc, m);
        c = 1; dc = -1; nd = 0; bb = 0;
        early = 64'd1; late = 64'd1;
        while (c <= TOT + 3) begin
            if (done === 1'b1) begin
                nd++;
                if (dc < 0) dc = c;
            end
            if (busy !== (c <= TOT - 1)) bb++;
            if (c == D + 1) early = mat_out[0][1];
            if (c == D + 2) late = mat_out[0][1];
            @(negedge clk);
            c++;
        end
        nvec++;
        if (dc !== TOT) begin
            nfail++;
            $display("FAIL ramp_done_cycle: got %0d expected %0d", dc, TOT);
        end
        nvec++;
        if (nd !== 1) begin
            nfail++;
            $display("FAIL ramp_done_pulses: got %0d expected 1", nd);
        end
        nvec++;
        if (bb !== 0) begin
            nfail++;
            $display("FAIL ramp_busy: %0d bad cycles expected 0", bb);
        end
        nvec++;
        if (early !== 64'd0) begin
            nfail++;
            $display("FAIL ramp_pre_capture: got %h expected 0", early);
        end
        nvec++;
        if (late !== $realtobits(-0.25)) begin
            nfail++;
            $display("FAIL ramp_g0_capture: got %h expected %h",
                     late, $realtobits(-0.25));
        end
        build_exp(sc, m, 64, e);
        k = first_diff(mat_out, e);
        nvec++;
        if (k !== -1) begin
            nfail++;
            $display("FAIL ramp_values: k=%0d got %h expected %h",
                     k, mat_out[k / 8][k % 8], e[k / 8][k % 8]);
        end
    endtask

    task automatic test_zero();
        mat8_t m, z;
        double sc;
        int k;
        z = '{default: 64'd0};
        for (int t = 0; t < 2; t++) begin
            sc = (t == 0) ? 64'h0 : 64'h8000_0000_0000_0000;
            rnd_mat(m);
            launch(sc, m);
            nvec++;
            if ({done, div_zero, busy} !== 3'b110) begin
                nfail++;
                $display("FAIL zero%0d_cycle1: got %b expected 110",
                         t, {done, div_zero, busy});
            end
            @(negedge clk);
            nvec++;
            if ({done, div_zero, busy} !== 3'b010) begin
                nfail++;
                $display("FAIL zero%0d_cycle2: got %b expected 010",
                         t, {done, div_zero, busy});
            end
            k = first_diff(mat_out, z);
            nvec++;
            if (k !== -1) begin
                nfail++;
                $display("FAIL zero%0d_mat_out: k=%0d got %h expected 0",
                         t, k, mat_out[k / 8][k % 8]);
            end
        end
    endtask

    task automatic test_random();
        mat8_t m, e;
        double sc;
        int dc, k;
        for (int t = 0; t < 3; t++) begin
            sc = rnd_dbl();
            rnd_mat(m);
            launch(sc, m);
            wait_done(dc);
            nvec++;
            if (dc !== TOT) begin
                nfail++;
                $display("FAIL rand%0d_done_cycle: got %0d expected %0d",
                         t, dc, TOT);
            end
            build_exp(sc, m, 64, e);
            @(negedge clk);
            k = first_diff(mat_out, e);
            nvec++;
            if (k !== -1) begin
                nfail++;
                $display("FAIL rand%0d_values: k=%0d got %h expected %h",
                         t, k, mat_out[k / 8][k % 8], e[k / 8][k % 8]);
            end
        end
    endtask

    task automatic test_start_held();
        mat8_t m0, e, z, r;
        double sc;
        int c, dc, k;
        z = '{default: 64'd0};
        sc = rnd_dbl();
        rnd_mat(m0);
        @(negedge clk);
        scale = sc;
        mat   = m0;
        start = 1'b1;
        c = 0; dc = -1;
        while (dc < 0 && c < 20000) begin
            @(negedge clk);
            c++;
            if (done === 1'b1) dc = c;
            rnd_mat(r);
            mat   = r;
            scale = rnd_dbl();
        end
        nvec++;
        if (dc !== TOT) begin
            nfail++;
            $display("FAIL held_done_cycle: got %0d expected %0d", dc, TOT);
        end
        @(negedge clk);
        build_exp(sc, m0, 64, e);
        k = first_diff(mat_out, e);
        nvec++;
        if (k !== -1) begin
            nfail++;
            $display("FAIL held_values: k=%0d got %h expected %h",
                     k, mat_out[k / 8][k % 8], e[k / 8][k % 8]);
        end
        nvec++;
        if (busy !== 1'b0) begin
            nfail++;
            $display("FAIL held_busy_after_done: got %b expected 0", busy);
        end
        @(negedge clk);
        nvec++;
        if (busy !== 1'b1) begin
            nfail++;
            $display("FAIL held_restart_busy: got %b expected 1", busy);
        end
        k = first_diff(mat_out, z);
        nvec++;
        if (k !== -1) begin
            nfail++;
            $display("FAIL held_restart_clear: k=%0d got %h expected 0",
                     k, mat_out[k / 8][k % 8]);
        end
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        nvec++;
        if (busy !== 1'b0) begin
            nfail++;
            $display("FAIL held_abort_issue: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_abort();
        mat8_t m, e;
        double sc;
        int nd, dc, k;
        sc = rnd_dbl();
        rnd_mat(m);
        launch(sc, m);
        repeat (D + 4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        nvec++;
        if (busy !== 1'b0) begin
            nfail++;
            $display("FAIL abort_busy: got %b expected 0", busy);
        end
        nd = 0;
        repeat (2 * D + 10) begin
            if (done === 1'b1) nd++;
            @(negedge clk);
        end
        nvec++;
        if (nd !== 0) begin
            nfail++;
            $display("FAIL abort_done_pulses: got %0d expected 0", nd);
        end
        build_exp(sc, m, 4, e);
        k = first_diff(mat_out, e);
        nvec++;
        if (k !== -1) begin
            nfail++;
            $display("FAIL abort_partial: k=%0d got %h expected %h",
                     k, mat_out[k / 8][k % 8], e[k / 8][k % 8]);
        end
        sc = rnd_dbl();
        rnd_mat(m);
        launch(sc, m);
        wait_done(dc);
        nvec++;
        if (dc !== TOT) begin
            nfail++;
            $display("FAIL abort_next_done: got %0d expected %0d", dc, TOT);
        end
        @(negedge clk);
        build_exp(sc, m, 64, e);
        k = first_diff(mat_out, e);
        nvec++;
        if (k !== -1) begin
            nfail++;
            $display("FAIL abort_next_values: k=%0d got %h expected %h",
                     k, mat_out[k / 8][k % 8], e[k / 8][k % 8]);
        end
    endtask

    task automatic test_reset_mid();
        mat8_t m, e, z;
        double sc;
        int dc, k;
        z = '{default: 64'd0};
        sc = rnd_dbl();
        rnd_mat(m);
        launch(sc, m);
        repeat (D + 9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({busy, done, div_zero} !== 3'b000) begin
            nfail++;
            $display("FAIL rst_mid_flags: got %b expected 000",
                     {busy, done, div_zero});
        end
        k = first_diff(mat_out, z);
        nvec++;
        if (k !== -1) begin
            nfail++;
            $display("FAIL rst_mid_mat_out: k=%0d got %h expected 0",
                     k, mat_out[k / 8][k % 8]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sc = rnd_dbl();
        rnd_mat(m);
        launch(sc, m);
        wait_done(dc);
        nvec++;
        if (dc !== TOT) begin
            nfail++;
            $display("FAIL rst_fresh_done: got %0d expected %0d", dc, TOT);
        end
        @(negedge clk);
        build_exp(sc, m, 64, e);
        k = first_diff(mat_out, e);
        nvec++;
        if (k !== -1) begin
            nfail++;
            $display("FAIL rst_fresh_values: k=%0d got %h expected %h",
                     k, mat_out[k / 8][k % 8], e[k / 8][k % 8]);
        end
    endtask

    task automatic test_back_to_back();
        mat8_t ma, mb, mc, e;
        double sa, sb, scc;
        int dc, k;
        sa = rnd_dbl();
        sb = rnd_dbl();
        scc = rnd_dbl();
        rnd_mat(ma);
        rnd_mat(mb);
        rnd_mat(mc);
        launch(sa, ma);
        wait_done(dc);
        nvec++;
        if (dc !== TOT) begin
            nfail++;
            $display("FAIL b2b_first_done: got %0d expected %0d", dc, TOT);
        end
        scale = scc;
        mat   = mc;
        start = 1'b1;
        @(negedge clk);
        scale = sb;
        mat   = mb;
        @(negedge clk);
        start = 1'b0;
        nvec++;
        if (busy !== 1'b1) begin
            nfail++;
            $display("FAIL b2b_second_busy: got %b expected 1", busy);
        end
        wait_done(dc);
        nvec++;
        if (dc !== TOT) begin
            nfail++;
            $display("FAIL b2b_second_done: got %0d expected %0d", dc, TOT);
        end
        @(negedge clk);
        build_exp(sb, mb, 64, e);
        k = first_diff(mat_out, e);
        nvec++;
        if (k !== -1) begin
            nfail++;
            $display("FAIL b2b_values: k=%0d got %h expected %h",
                     k, mat_out[k / 8][k % 8], e[k / 8][k % 8]);
        end
    endtask

    initial begin
        mat   = '{default: 64'd0};
        s_mat = '{default: 64'd0};
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_small();
        test_ramp();
        test_zero();
        test_random();
        test_start_held();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
